// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding and nibble sizing helpers
package nibble_serial_adder_pkg;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;
    localparam int NIB_W = 4;
    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction
    function automatic int idx_width(input int width);
        return $clog2(width / NIB_W);
    endfunction
endpackage

// File: rtl/nibble_serial_adder_cla.sv
// cla_4: combinational 4-bit carry-lookahead adder
module cla_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a_i & b_i;
    assign p = a_i ^ b_i;
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign sum_o = p ^ c[3:0];
    assign c_o   = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle add/sub, one nibble per clock through a single cla_4
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);

    if (WIDTH % NIB_W != 0 || WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 8");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             c_q, c_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    cla_4 u_cla (
        .a_i  (a_q[{idx_q, 2'b00} +: NIB_W]),
        .b_i  (b_q[{idx_q, 2'b00} +: NIB_W]),
        .c_i  (c_q),
        .sum_o(nib_sum),
        .c_o  (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        idx_d   = idx_q;
        if (state_q == S_IDLE && in_valid) begin
            a_d     = in_a;
            b_d     = in_sub ? ~in_b : in_b;
            c_d     = in_sub;
            sum_d   = '0;
            idx_d   = '0;
            state_d = S_RUN;
        end
        if (state_q == S_RUN) begin
            sum_d[{idx_q, 2'b00} +: NIB_W] = nib_sum;
            c_d     = nib_cout;
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == IDX_W'(NIB - 1)) ? S_DONE : S_RUN;
        end
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign out_sum   = sum_q;
    assign out_cout  = c_q;
    assign out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
    assign out_zero  = ~|sum_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed-vector self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic        out_cout, out_ovf, out_zero;
    logic [31:0] in_a, in_b, out_sum;
    int          n_vec = 0;
    int          n_err = 0;

    nibble_serial_adder #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, measure latency to out_valid and check results while held in DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] e_sum, input logic e_cout, input logic e_ovf, input logic e_zero);
        int k;
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 30) begin
            tick();
            k++;
        end
        chk({tag, ".rdy"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, ".lat"}, k, 8);
        chk({tag, ".sum"}, out_sum, e_sum);
        chk({tag, ".cout"}, out_cout, e_cout);
        chk({tag, ".ovf"}, out_ovf, e_ovf);
        chk({tag, ".zero"}, out_zero, e_zero);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".vld_drop"}, out_valid, 1'b0);
        chk({tag, ".rdy_back"}, in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.sum", out_sum, 32'h0);
        chk("rst.zero", out_zero, 1'b1);
        chk("rst.cout", out_cout, 1'b0);
        chk("rst.ovf", out_ovf, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("idle.in_ready", in_ready, 1'b1);
        chk("idle.out_valid", out_valid, 1'b0);

        run_op("add5p3", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        release_out("add5p3");
        run_op("addwrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        release_out("addwrap");
        run_op("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        release_out("addovf");
        run_op("sub3m5", 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        release_out("sub3m5");
        run_op("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Hold the subovf result in DONE while a competing request is presented.
        in_valid = 1'b1;
        in_a = 32'h1111_1111;
        in_b = 32'h2222_2222;
        in_sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.out_valid", out_valid, 1'b1);
            chk("bp.in_ready", in_ready, 1'b0);
            chk("bp.sum", out_sum, 32'h7FFF_FFFF);
            chk("bp.flags", {out_cout, out_ovf, out_zero}, 3'b110);
        end
        in_valid = 1'b0;
        release_out("bp");

        // Reset while nibble 3 is in flight.
        in_a = 32'hFFFF_FFFF;
        in_b = 32'hFFFF_FFFF;
        in_sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid.busy", in_ready, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.in_ready", in_ready, 1'b1);
        chk("mid.out_valid", out_valid, 1'b0);
        chk("mid.sum", out_sum, 32'h0);
        chk("mid.zero", out_zero, 1'b1);
        chk("mid.cout", out_cout, 1'b0);
        chk("mid.ovf", out_ovf, 1'b0);

        run_op("post", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        release_out("post");
        run_op("subeq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        release_out("subeq");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
